// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op encodings, status bit positions
// and the controller state set.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_MVN = 3'b011,
    ALU_MUL = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_CMP = 3'b111
  } alu_op_t;

  localparam int N_BIT = 2;
  localparam int V_BIT = 1;
  localparam int Z_BIT = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add unsigned multiplier, one partial product per clock.
// product already includes the step taken on the coming edge, so the edge
// where last=1 can capture the complete result.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign product = acc + (mplier[0] ? mcand : '0);
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with N/V/Z status and a start/busy/done handshake; MUL runs
// iteratively over WIDTH cycles, every other op completes in one.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       status,
  output logic             busy,
  output logic             done
);

  alu_op_t            op;
  state_t             state;
  logic [WIDTH-1:0]   res;
  logic               res_v;
  logic [2:0]         res_flags;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_last;
  logic               mul_load;
  logic [WIDTH-1:0]   mul_lo;
  logic [2:0]         mul_flags;

  assign op = alu_op_t'(ALUop);

  // Overflow for add/subtract: operand signs (B inverted for subtract) agree
  // but the result sign differs -- same as carry-in XOR carry-out of the MSB.
  always_comb begin
    res   = '0;
    res_v = 1'b0;
    unique case (op)
      ALU_ADD: begin
        res   = Ain + Bin;
        res_v = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
      end
      ALU_SUB, ALU_CMP: begin
        res   = Ain - Bin;
        res_v = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
      end
      ALU_AND: res = Ain & Bin;
      ALU_MVN: res = ~Bin;
      ALU_OR:  res = Ain | Bin;
      ALU_XOR: res = Ain ^ Bin;
      default: res = '0;
    endcase
  end

  always_comb begin
    res_flags        = '0;
    res_flags[N_BIT] = res[WIDTH-1];
    res_flags[V_BIT] = res_v;
    res_flags[Z_BIT] = (res == '0);
  end

  assign mul_lo = mul_product[WIDTH-1:0];

  always_comb begin
    mul_flags        = '0;
    mul_flags[N_BIT] = mul_lo[WIDTH-1];
    mul_flags[V_BIT] = |mul_product[2*WIDTH-1:WIDTH];
    mul_flags[Z_BIT] = (mul_lo == '0);
  end

  assign mul_load = (state == IDLE) && start && (op == ALU_MUL);

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .a       (Ain),
        .b       (Bin),
        .product (mul_product),
        .last    (mul_last)
      );
    end else begin : g_no_mul
      assign mul_product = '0;
      assign mul_last    = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      out    <= '0;
      status <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (op == ALU_MUL) begin
              if (MUL_EN) begin
                state <= MUL;
                busy  <= 1'b1;
              end else begin
                out    <= '0;
                status <= '0;
                done   <= 1'b1;
              end
            end else begin
              if (op != ALU_CMP) out <= res;
              status <= res_flags;
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_last) begin
            out    <= mul_lo;
            status <= mul_flags;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16, MUL_EN=1); expected
// values below are worked out by hand from the op definitions.
module tb_seq_alu;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       ALUop;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic [WIDTH-1:0] out;
  logic [2:0]       status;
  logic             busy;
  logic             done;

  int vectors     = 0;
  int miscompares = 0;

  seq_alu #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ALUop  (ALUop),
    .Ain    (Ain),
    .Bin    (Bin),
    .out    (out),
    .status (status),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one edge, then sample 1 time unit later.
  task automatic apply_stimulus(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    ALUop = op;
    Ain   = a;
    Bin   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b1;
    ALUop = 3'b000;
    Ain   = 16'd5;
    Bin   = 16'd3;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_out", 32'(out), 32'h0);
    check_output("reset_status", 32'(status), 32'h0);
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_done", 32'(done), 32'h0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 7FFF + 1 overflows into the sign bit
    apply_stimulus(3'b000, 16'h7FFF, 16'h0001);
    check_output("add_ovf_out", 32'(out), 32'h8000);
    check_output("add_ovf_status", 32'(status), 32'h6);
    check_output("add_ovf_done", 32'(done), 32'h1);
    @(posedge clk);
    #1;
    check_output("add_ovf_done_pulse", 32'(done), 32'h0);

    apply_stimulus(3'b000, 16'd2, 16'd2);
    check_output("add_2_2_out", 32'(out), 32'h4);
    check_output("add_2_2_status", 32'(status), 32'h0);
    apply_stimulus(3'b111, 16'h0005, 16'h0005);
    check_output("cmp_eq_status", 32'(status), 32'h1);
    check_output("cmp_eq_out_hold", 32'(out), 32'h4);
    apply_stimulus(3'b111, 16'h0003, 16'h0005);
    check_output("cmp_lt_status", 32'(status), 32'h4);
    check_output("cmp_lt_out_hold", 32'(out), 32'h4);

    // Back-to-back single-cycle ops with start held high
    start = 1'b1;
    ALUop = 3'b010; Ain = 16'hF0F0; Bin = 16'hFF00;
    @(posedge clk); #1;
    check_output("b2b_and_out", 32'(out), 32'hF000);
    check_output("b2b_and_status", 32'(status), 32'h4);
    check_output("b2b_and_done", 32'(done), 32'h1);
    ALUop = 3'b101; Ain = 16'hF0F0; Bin = 16'h0F0F;
    @(posedge clk); #1;
    check_output("b2b_or_out", 32'(out), 32'hFFFF);
    check_output("b2b_or_status", 32'(status), 32'h4);
    check_output("b2b_or_done", 32'(done), 32'h1);
    ALUop = 3'b110; Ain = 16'hFFFF; Bin = 16'hFFFF;
    @(posedge clk); #1;
    check_output("b2b_xor_out", 32'(out), 32'h0000);
    check_output("b2b_xor_status", 32'(status), 32'h1);
    check_output("b2b_xor_done", 32'(done), 32'h1);
    ALUop = 3'b011; Ain = 16'h1234; Bin = 16'h0000;
    @(posedge clk); #1;
    check_output("b2b_mvn_out", 32'(out), 32'hFFFF);
    check_output("b2b_mvn_status", 32'(status), 32'h4);
    check_output("b2b_mvn_done", 32'(done), 32'h1);
    start = 1'b0;
    @(posedge clk); #1;
    check_output("b2b_done_drop", 32'(done), 32'h0);

    // 300 * 200 = 60000 = 16'hEA60, no unsigned overflow
    apply_stimulus(3'b100, 16'd300, 16'd200);
    check_output("mul1_busy_e1", 32'(busy), 32'h1);
    check_output("mul1_done_e1", 32'(done), 32'h0);
    for (int e = 2; e <= 16; e++) begin
      if (e == 5 || e == 10) begin
        start = 1'b1; ALUop = 3'b000; Ain = 16'd1; Bin = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      check_output($sformatf("mul1_busy_e%0d", e), 32'(busy), 32'h1);
      check_output($sformatf("mul1_done_e%0d", e), 32'(done), 32'h0);
      check_output($sformatf("mul1_out_hold_e%0d", e), 32'(out), 32'hFFFF);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check_output("mul1_out", 32'(out), 32'hEA60);
    check_output("mul1_status", 32'(status), 32'h4);
    check_output("mul1_done", 32'(done), 32'h1);
    check_output("mul1_busy_clear", 32'(busy), 32'h0);

    // Accepted in the done cycle; 0x100*0x100 = 0x10000 -> low half zero, V set
    apply_stimulus(3'b100, 16'h0100, 16'h0100);
    check_output("mul2_busy", 32'(busy), 32'h1);
    wait_done(n);
    check_output("mul2_latency", 32'(n), 32'd16);
    check_output("mul2_out", 32'(out), 32'h0);
    check_output("mul2_status", 32'(status), 32'h3);

    // Abort a multiply with reset at its 8th cycle
    apply_stimulus(3'b100, 16'd7, 16'd9);
    repeat (6) @(posedge clk);
    #1;
    check_output("abort_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_output("abort_busy", 32'(busy), 32'h0);
    check_output("abort_done", 32'(done), 32'h0);
    check_output("abort_out", 32'(out), 32'h0);
    check_output("abort_status", 32'(status), 32'h0);
    for (int e = 0; e < 18; e++) begin
      @(posedge clk); #1;
      check_output($sformatf("abort_no_done_%0d", e), 32'(done), 32'h0);
    end
    apply_stimulus(3'b000, 16'd1, 16'd1);
    check_output("post_abort_out", 32'(out), 32'h2);
    check_output("post_abort_status", 32'(status), 32'h0);
    check_output("post_abort_done", 32'(done), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
